// File: rtl/if_stage_pkg.sv
// Shared definitions for the RV32 fetch stage: constants, fetch FSM states and
// the IF/ID payload layout.
package if_stage_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] IF_NOP_INSTR = 32'h0000_0013;  // addi x0,x0,0
  localparam logic [XLEN-1:0] IF_RESET_PC  = 32'h0000_0000;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic            valid;
  } if_id_t;
endpackage

// File: rtl/if_stage_if_id_reg.sv
// Pipeline register between two stages with flush > hold > load > bubble priority.
module if_id_reg
  import if_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] NOP = IF_NOP_INSTR
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   flush,
  input  logic   write_en,
  input  logic   load,
  input  if_id_t load_data,
  output if_id_t q
);
  if_id_t q_q, q_d;

  // Flush and bubble keep the pc so ID still sees where the hole came from.
  always_comb begin
    q_d = q_q;
    if (flush) begin
      q_d.valid = 1'b0;
      q_d.instr = NOP;
    end else if (!write_en) begin
      q_d = q_q;
    end else if (load) begin
      q_d       = load_data;
      q_d.valid = 1'b1;
    end else begin
      q_d.valid = 1'b0;
      q_d.instr = NOP;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q.pc    <= '0;
      q_q.instr <= NOP;
      q_q.valid <= 1'b0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;
endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, single-outstanding imem handshake and IF/ID register.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = IF_RESET_PC,
  parameter logic [XLEN-1:0] NOP_INSTR = IF_NOP_INSTR
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pc_write,
  input  logic            if_id_write,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] if_id_pc,
  output logic [XLEN-1:0] if_id_instr,
  output logic            if_id_valid,
  output logic            fetch_busy
);
  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic            drop_q, drop_d;
  if_id_t          buf_q, buf_d;
  logic            deliver;
  if_id_t          deliver_data;
  if_id_t          if_id_q;

  always_comb begin
    imem_req     = (state_q == REQ) && pc_write && !branch_taken;
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    req_pc_d     = req_pc_q;
    drop_d       = drop_q;
    buf_d        = buf_q;
    deliver      = 1'b0;
    deliver_data = buf_q;

    case (state_q)
      REQ: begin
        if (imem_req && imem_ready) begin
          req_pc_d = fetch_pc_q;
          state_d  = WAIT;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          state_d = REQ;
          if (drop_q) begin
            drop_d = 1'b0;
          end else if (!branch_taken) begin
            if (if_id_write) begin
              deliver      = 1'b1;
              deliver_data = '{pc: req_pc_q, instr: imem_rdata, valid: 1'b1};
            end else begin
              buf_d   = '{pc: req_pc_q, instr: imem_rdata, valid: 1'b1};
              state_d = HOLD;
            end
          end
        end else if (branch_taken) begin
          // Response still in flight belongs to the wrong path; swallow it later.
          drop_d = 1'b1;
        end
      end
      HOLD: begin
        if (branch_taken) begin
          state_d = REQ;
        end else if (if_id_write) begin
          deliver = 1'b1;
          state_d = REQ;
        end
      end
      default: state_d = REQ;
    endcase

    if (branch_taken)                fetch_pc_d = branch_target;
    else if (imem_req && imem_ready) fetch_pc_d = fetch_pc_q + 32'd4;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= REQ;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= '0;
      drop_q     <= 1'b0;
      buf_q      <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      drop_q     <= drop_d;
      buf_q      <= buf_d;
    end
  end

  if_id_reg #(.NOP(NOP_INSTR)) u_if_id (
    .clk       (clk),
    .rst       (rst),
    .flush     (branch_taken),
    .write_en  (if_id_write),
    .load      (deliver),
    .load_data (deliver_data),
    .q         (if_id_q)
  );

  assign imem_addr   = fetch_pc_q;
  assign fetch_busy  = (state_q != REQ);
  assign if_id_pc    = if_id_q.pc;
  assign if_id_instr = if_id_q.instr;
  assign if_id_valid = if_id_q.valid;
endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios plus random traffic against a
// transaction-level model of the fetch stage and a latency-programmable imem.
module tb_if_stage;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk, rst;
  logic        pc_write, if_id_write, branch_taken;
  logic [31:0] branch_target;
  logic        imem_req, imem_ready, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] if_id_pc, if_id_instr;
  logic        if_id_valid, fetch_busy;

  int vecs, errs;

  if_stage dut (
    .clk(clk), .rst(rst), .pc_write(pc_write), .if_id_write(if_id_write),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .if_id_pc(if_id_pc), .if_id_instr(if_id_instr), .if_id_valid(if_id_valid),
    .fetch_busy(fetch_busy)
  );

  always #5 clk = ~clk;

  // memory: one pending response, returned lat cycles after acceptance
  bit          mem_busy;
  int          mem_cnt, lat;
  logic [31:0] mem_addr;

  // model: next fetch address, outstanding request, stale flag, parked response, IF/ID
  logic [31:0] m_pc, m_opc, m_bpc, m_bins, m_ipc, m_ins;
  bit          m_pend, m_stale, m_buf, m_v;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h0000_0003;
  endfunction

  function automatic bit mdl_req();
    return !m_pend && !m_buf && pc_write && !branch_taken;
  endfunction

  task automatic model_reset();
    m_pc = 32'h0; m_pend = 0; m_stale = 0; m_buf = 0;
    m_v = 0; m_ipc = 32'h0; m_ins = NOP;
    mem_busy = 0; mem_cnt = 0; imem_rvalid = 0;
  endtask

  task automatic drive_mem();
    imem_rvalid = mem_busy && (mem_cnt == 1);
    imem_rdata  = imem_rvalid ? instr_of(mem_addr) : $urandom();
    #1;
  endtask

  task automatic clk_edge();
    bit          acc, dl, macc;
    logic [31:0] dpc, dins, maddr;
    acc = mdl_req() && imem_ready;
    dl = 0; dpc = 0; dins = 0;
    if (m_buf) begin
      if (branch_taken) m_buf = 0;
      else if (if_id_write) begin dl = 1; dpc = m_bpc; dins = m_bins; m_buf = 0; end
    end
    if (m_pend) begin
      if (imem_rvalid) begin
        m_pend = 0;
        if (m_stale) m_stale = 0;
        else if (!branch_taken) begin
          if (if_id_write) begin dl = 1; dpc = m_opc; dins = imem_rdata; end
          else begin m_buf = 1; m_bpc = m_opc; m_bins = imem_rdata; end
        end
      end else if (branch_taken) m_stale = 1;
    end
    if (acc) begin m_pend = 1; m_opc = m_pc; end
    if (branch_taken) m_pc = branch_target;
    else if (acc) m_pc = m_pc + 32'd4;
    if (branch_taken) begin m_v = 0; m_ins = NOP; end
    else if (!if_id_write) ;
    else if (dl) begin m_v = 1; m_ipc = dpc; m_ins = dins; end
    else begin m_v = 0; m_ins = NOP; end
    macc = imem_req && imem_ready; maddr = imem_addr;
    @(posedge clk); #1;
    if (imem_rvalid) mem_busy = 0;
    else if (mem_busy) mem_cnt--;
    if (macc) begin mem_busy = 1; mem_cnt = lat; mem_addr = maddr; end
    imem_rvalid = 0;
  endtask

  task automatic drain();
    pc_write = 0; if_id_write = 1; branch_taken = 0; imem_ready = 1;
    for (int i = 0; i < 6; i++) begin drive_mem(); clk_edge(); end
  endtask

  task automatic test_reset();
    rst = 1; pc_write = 0; if_id_write = 1; branch_taken = 0; imem_ready = 1;
    model_reset();
    @(posedge clk); #3;
    vecs++;
    if ({if_id_valid, if_id_pc, if_id_instr, fetch_busy, imem_addr} !== {1'b0, 32'h0, NOP, 1'b0, 32'h0})
      $display("FAIL reset: got v=%0b pc=%h instr=%h busy=%0b addr=%h", if_id_valid, if_id_pc, if_id_instr, fetch_busy, imem_addr);
    if ({if_id_valid, if_id_pc, if_id_instr, fetch_busy, imem_addr} !== {1'b0, 32'h0, NOP, 1'b0, 32'h0}) errs++;
    @(posedge clk); #1; rst = 0;
  endtask

  task automatic test_stream();
    logic [31:0] base;
    int nreq;
    pc_write = 1; if_id_write = 1; branch_taken = 0; imem_ready = 1; lat = 1;
    base = m_pc; nreq = 0;
    for (int i = 0; i < 8; i++) begin
      drive_mem();
      vecs++;
      if (imem_req !== mdl_req() || (imem_req && imem_addr !== base + 32'(4 * nreq))) begin
        errs++; $display("FAIL stream_req: got req=%0b addr=%h exp req=%0b addr=%h", imem_req, imem_addr, mdl_req(), base + 32'(4 * nreq));
      end
      if (mdl_req()) nreq++;
      clk_edge();
      vecs++;
      if ({if_id_valid, if_id_pc, if_id_instr} !== {m_v, m_ipc, m_ins} || if_id_valid !== (i % 2 == 1)) begin
        errs++; $display("FAIL stream_ifid: got v=%0b pc=%h instr=%h exp v=%0b pc=%h instr=%h", if_id_valid, if_id_pc, if_id_instr, m_v, m_ipc, m_ins);
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] x;
    logic [64:0] snap;
    x = m_pc; pc_write = 1; if_id_write = 1; branch_taken = 0; imem_ready = 1; lat = 1;
    drive_mem();
    vecs++;
    if (imem_req !== 1'b1 || imem_addr !== x) begin
      errs++; $display("FAIL stall_issue: got req=%0b addr=%h exp 1 %h", imem_req, imem_addr, x);
    end
    clk_edge();
    snap = {m_v, m_ipc, m_ins};
    pc_write = 0; if_id_write = 0;
    for (int i = 0; i < 3; i++) begin
      drive_mem();
      vecs++;
      if (imem_req !== 1'b0) begin errs++; $display("FAIL stall_req: got %0b exp 0", imem_req); end
      clk_edge();
      vecs++;
      if ({if_id_valid, if_id_pc, if_id_instr} !== snap || fetch_busy !== 1'b1) begin
        errs++; $display("FAIL stall_hold: got %h busy=%0b exp %h busy=1", {if_id_valid, if_id_pc, if_id_instr}, fetch_busy, snap);
      end
    end
    pc_write = 1; if_id_write = 1;
    drive_mem(); clk_edge();
    vecs++;
    if ({if_id_valid, if_id_pc, if_id_instr} !== {1'b1, x, instr_of(x)}) begin
      errs++; $display("FAIL stall_release: got v=%0b pc=%h instr=%h exp 1 %h %h", if_id_valid, if_id_pc, if_id_instr, x, instr_of(x));
    end
    drive_mem();
    vecs++;
    if (imem_req !== 1'b1 || imem_addr !== x + 32'd4) begin
      errs++; $display("FAIL stall_next: got req=%0b addr=%h exp 1 %h", imem_req, imem_addr, x + 32'd4);
    end
    clk_edge();
    drain();
  endtask

  task automatic test_branch_wait();
    bit seen;
    pc_write = 1; if_id_write = 1; branch_taken = 0; imem_ready = 1; lat = 3;
    drive_mem(); clk_edge();
    branch_taken = 1; branch_target = 32'h100;
    drive_mem(); clk_edge();
    branch_taken = 0;
    vecs++;
    if (if_id_valid !== 1'b0 || if_id_instr !== 32'h13) begin
      errs++; $display("FAIL bw_flush: got v=%0b instr=%h exp 0 00000013", if_id_valid, if_id_instr);
    end
    seen = 0;
    for (int i = 0; i < 6 && !seen; i++) begin
      drive_mem();
      if (imem_req) begin
        seen = 1; vecs++;
        if (imem_addr !== 32'h100) begin errs++; $display("FAIL bw_target: got %h exp 00000100", imem_addr); end
      end
      clk_edge();
      vecs++;
      if (!seen && if_id_valid !== 1'b0) begin errs++; $display("FAIL bw_stale: got v=%0b pc=%h exp v=0", if_id_valid, if_id_pc); end
    end
    vecs++;
    if (!seen) begin errs++; $display("FAIL bw_timeout: got no request exp request to 00000100"); end
    drain();
  endtask

  task automatic test_branch_rvalid();
    pc_write = 1; if_id_write = 1; branch_taken = 0; imem_ready = 1; lat = 1;
    drive_mem(); clk_edge();
    branch_taken = 1; branch_target = 32'h100;
    drive_mem(); clk_edge();
    branch_taken = 0;
    vecs++;
    if (if_id_valid !== 1'b0 || if_id_instr !== 32'h13) begin
      errs++; $display("FAIL br_rv_flush: got v=%0b instr=%h exp 0 00000013", if_id_valid, if_id_instr);
    end
    drive_mem();
    vecs++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin
      errs++; $display("FAIL br_rv_next: got req=%0b addr=%h exp 1 00000100", imem_req, imem_addr);
    end
    clk_edge();
    drain();
  endtask

  task automatic test_ready_low();
    logic [31:0] a0;
    pc_write = 1; if_id_write = 1; branch_taken = 0; imem_ready = 0; lat = 1;
    a0 = m_pc;
    for (int i = 0; i < 4; i++) begin
      drive_mem();
      vecs++;
      if (imem_req !== 1'b1 || imem_addr !== a0 || fetch_busy !== 1'b0) begin
        errs++; $display("FAIL rdy_low_req: got req=%0b addr=%h busy=%0b exp 1 %h 0", imem_req, imem_addr, fetch_busy, a0);
      end
      clk_edge();
      vecs++;
      if (if_id_valid !== 1'b0) begin errs++; $display("FAIL rdy_low_bubble: got v=%0b exp 0", if_id_valid); end
    end
    drain();
  endtask

  task automatic test_async_reset();
    pc_write = 1; if_id_write = 1; branch_taken = 0; imem_ready = 1; lat = 3;
    drive_mem(); clk_edge();
    drive_mem();
    rst = 1; #1;
    vecs++;
    if ({if_id_valid, if_id_pc, if_id_instr, fetch_busy, imem_addr} !== {1'b0, 32'h0, NOP, 1'b0, 32'h0}) begin
      errs++; $display("FAIL async_rst: got v=%0b pc=%h instr=%h busy=%0b addr=%h", if_id_valid, if_id_pc, if_id_instr, fetch_busy, imem_addr);
    end
    model_reset();
    @(posedge clk); #1; rst = 0;
    drive_mem();
    vecs++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      errs++; $display("FAIL async_rst_first: got req=%0b addr=%h exp 1 00000000", imem_req, imem_addr);
    end
    clk_edge();
    drain();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      pc_write      = $urandom_range(0, 9) != 0;
      if_id_write   = $urandom_range(0, 3) != 0;
      branch_taken  = $urandom_range(0, 9) == 0;
      branch_target = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
      imem_ready    = $urandom_range(0, 3) != 0;
      lat           = $urandom_range(1, 4);
      drive_mem();
      vecs++;
      if (imem_req !== mdl_req() || imem_addr !== m_pc || fetch_busy !== (m_pend || m_buf)) begin
        errs++; $display("FAIL rnd_fetch @%0d: got req=%0b addr=%h busy=%0b exp %0b %h %0b", i, imem_req, imem_addr, fetch_busy, mdl_req(), m_pc, m_pend || m_buf);
      end
      clk_edge();
      vecs++;
      if ({if_id_valid, if_id_pc, if_id_instr} !== {m_v, m_ipc, m_ins}) begin
        errs++; $display("FAIL rnd_ifid @%0d: got v=%0b pc=%h instr=%h exp v=%0b pc=%h instr=%h", i, if_id_valid, if_id_pc, if_id_instr, m_v, m_ipc, m_ins);
      end
    end
  endtask

  initial begin
    clk = 0; vecs = 0; errs = 0; lat = 1;
    rst = 1; pc_write = 0; if_id_write = 1; branch_taken = 0; branch_target = 32'h0;
    imem_ready = 1; imem_rvalid = 0; imem_rdata = 32'h0; mem_addr = 32'h0;
    m_opc = 0; m_bpc = 0; m_bins = 0;
    test_reset();
    test_stream();
    test_stall();
    test_branch_wait();
    test_branch_rvalid();
    test_ready_low();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage RV32 pipeline.
- Owns the PC register, a single-outstanding instruction-memory request/response handshake and the IF/ID pipeline register.
- Consumes `pc_write` / `if_id_write` from the load-use hazard detector and the branch redirect from EX.
- Feeds ID with `{pc, instr, valid}`, inserting bubbles on stall, memory latency or flush.

Parameters:
- RESET_PC, 32'h0000_0000, fetch address after reset.
- NOP_INSTR, 32'h0000_0013, encoding driven into IF/ID on bubble/flush (addi x0,x0,0).

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- pc_write  input  1  0 = do not issue a new fetch (hazard stall).
- if_id_write  input  1  0 = IF/ID holds its contents.
- branch_taken  input  1  redirect/flush request from EX.
- branch_target  input  32  redirect address, word aligned.
- imem_req  output  1  fetch request valid.
- imem_addr  output  32  fetch address.
- imem_ready  input  1  memory accepts the request this cycle.
- imem_rvalid  input  1  response data valid.
- imem_rdata  input  32  instruction word.
- if_id_pc  output  32  PC of the instruction in IF/ID.
- if_id_instr  output  32  instruction in IF/ID.
- if_id_valid  output  1  IF/ID holds a real instruction.
- fetch_busy  output  1  a request is outstanding or buffered (state != REQ).

Behaviour:
- Reset (async, rst=1):
  - fetch_pc=RESET_PC, state=REQ, drop=0.
  - if_id_valid=0, if_id_pc=0, if_id_instr=NOP_INSTR, hold buffer cleared.
- Outputs:
  - imem_req = (state==REQ) & pc_write & ~branch_taken (combinational).
  - imem_addr = fetch_pc.
- REQ:
  - On imem_req & imem_ready: req_pc<=fetch_pc, fetch_pc<=fetch_pc+4 (32-bit wrap), go to WAIT.
  - Otherwise stay in REQ.
- WAIT, on imem_rvalid:
  - drop=1: discard data, drop<=0, go to REQ.
  - Else if branch_taken: discard data, go to REQ.
  - Else if if_id_write=1: IF/ID<={req_pc, imem_rdata, 1}, go to REQ.
  - Else: buffer {req_pc, imem_rdata}, go to HOLD.
- WAIT, no imem_rvalid, branch_taken: drop<=1, stay in WAIT. The stale response is discarded whenever it arrives.
- HOLD:
  - if_id_write=1 & ~branch_taken: IF/ID<=buffer, go to REQ.
  - branch_taken: discard buffer, go to REQ.
- Redirect:
  - branch_taken in any state sets fetch_pc<=branch_target.
  - This takes priority over the +4 advance.
  - Its REQ-state request is suppressed that cycle.
- IF/ID priority, highest first:
  1. branch_taken → valid<=0, instr<=NOP_INSTR, pc unchanged.
  2. if_id_write=0 → hold.
  3. Delivery this cycle → load.
  4. Otherwise → bubble: valid<=0, instr<=NOP_INSTR.
- Throughput: at most one instruction per 2 cycles (REQ, then WAIT); imem latency ≥1 cycle.
- Invariants:
  - Never more than one outstanding request.
  - A response is never written to IF/ID while drop=1.
- Reset during WAIT/HOLD abandons the request. The memory system must itself ignore a late response after rst.

Decomposition:
- Shared pipeline package holds: NOP_INSTR, RESET_PC default, XLEN=32, the fetch FSM state enum {REQ, WAIT, HOLD}, and the IF/ID payload struct {pc, instr, valid}.
- One sub-module is natural: if_id_reg. It implements the IF/ID register with load/hold/flush/bubble priority and is reused by the ID/EX design pattern.
- PC and FSM stay in if_stage.

Test Plan:
- Reset release, imem always ready, 1-cycle rvalid:
  - imem_addr sequence 0x0, 0x4, 0x8.
  - if_id_pc follows with valid alternating 1/0 (bubble every other cycle).
  - instr matches rdata.
- Stall: hold if_id_write=0 and pc_write=0 for 3 cycles while a response arrives:
  - response captured in HOLD; IF/ID unchanged; imem_req=0.
  - On release, IF/ID loads the buffered pc/instr; next fetch is req_pc+4.
- Branch while WAIT (rvalid delayed 3 cycles), branch_target=0x100:
  - if_id_valid=0 and instr=0x00000013 next cycle.
  - Late response discarded.
  - Next request address is 0x100.
- Branch coincident with rvalid in WAIT: data discarded, IF/ID flushed, next imem_addr=0x100.
- imem_ready low for 4 cycles: imem_req stays high with a stable address, fetch_busy=0, IF/ID shows bubbles.
- Async rst asserted mid-WAIT:
  - Outputs return to reset values immediately without a clock edge.
  - After release, first imem_addr=RESET_PC.
